// File: rtl/flash_reader_pkg.sv
// Shared types and helpers for the flash byte reader: FSM states, request size limit
// and the request-length clamp.
package flash_reader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_e;

  localparam int unsigned MAX_BYTES_PER_REQ = 4;

  // A length of 0 means one byte; anything past the word size is cut to a full word.
  function automatic logic [2:0] clamp_len(input logic [2:0] len);
    if (len == 3'd0) return 3'd1;
    if (len > 3'(MAX_BYTES_PER_REQ)) return 3'(MAX_BYTES_PER_REQ);
    return len;
  endfunction

endpackage

// File: rtl/flash_reader_watchdog.sv
// Per-byte watchdog for the flash byte reader: clears on each strobe, counts while a
// byte is outstanding and flags expiry at TIMEOUT_CYCLES.
module flash_reader_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic count,
  output logic expired
);

  localparam int unsigned CntWidth =
      ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CntWidth-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (count && !expired) begin
      cnt_q <= cnt_q + CntWidth'(1);
    end
  end

  assign expired = (cnt_q == CntWidth'(TIMEOUT_CYCLES));

endmodule

// File: rtl/flash_byte_reader.sv
// Sequences 1-4 single-byte flash reads behind the boot loader and packs them little-endian.
// Optional per-byte watchdog enabled by defining FLASH_READER_TIMEOUT_EN.
module flash_byte_reader
  import flash_reader_pkg::*;
#(
  parameter int unsigned FLASH_BYTE_ADDR_WIDTH = 15,
  parameter int unsigned TIMEOUT_CYCLES        = 255
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic [3:0]                       req_page,
  input  logic [FLASH_BYTE_ADDR_WIDTH-1:0] req_byte_addr,
  input  logic [2:0]                       req_len,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [31:0]                      rsp_data,
  output logic                             rsp_error,
  input  logic                             loader_done,
  output logic                             flash_read_enable,
  output logic [3:0]                       page_index,
  output logic [FLASH_BYTE_ADDR_WIDTH-1:0] flash_byte_addr,
  input  logic                             flash_read_en_out,
  input  logic [7:0]                       flash_byte_out
);

  state_e                           state_q, state_d;
  logic [3:0]                       page_q;
  logic [FLASH_BYTE_ADDR_WIDTH-1:0] addr_q;
  logic [2:0]                       len_q;
  logic [2:0]                       idx_q;
  logic [31:0]                      data_q;
  logic                             accept;
  logic                             byte_in;
  logic                             timeout;

  assign req_ready = (state_q == S_IDLE) && loader_done;
  assign accept    = req_valid && req_ready;
  // Loader pulses outside S_WAIT are stray and must not touch the datapath.
  assign byte_in   = (state_q == S_WAIT) && flash_read_en_out;

  always_comb begin
    state_d           = state_q;
    flash_read_enable = 1'b0;
    rsp_valid         = 1'b0;
    unique case (state_q)
      S_IDLE:  if (accept) state_d = S_SETUP;
      S_SETUP: state_d = S_ISSUE;
      S_ISSUE: begin
        flash_read_enable = 1'b1;
        state_d           = S_WAIT;
      end
      S_WAIT: begin
        if (byte_in) begin
          state_d = (idx_q + 3'd1 == len_q) ? S_RESP : S_ISSUE;
        end else if (timeout) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      page_q <= '0;
      addr_q <= '0;
      len_q  <= '0;
      idx_q  <= '0;
      data_q <= '0;
    end else if (accept) begin
      page_q <= req_page;
      addr_q <= req_byte_addr;
      len_q  <= clamp_len(req_len);
      idx_q  <= '0;
      data_q <= '0;
    end else if (byte_in) begin
      data_q[{idx_q[1:0], 3'b000} +: 8] <= flash_byte_out;
      idx_q  <= idx_q + 3'd1;
      addr_q <= addr_q + FLASH_BYTE_ADDR_WIDTH'(1);
    end
  end

  assign rsp_data        = data_q;
  assign page_index      = page_q;
  assign flash_byte_addr = addr_q;

`ifdef FLASH_READER_TIMEOUT_EN
  logic err_q;
  logic wd_clear;
  logic wd_count;

  assign wd_clear = (state_q == S_ISSUE);
  assign wd_count = (state_q == S_WAIT);

  flash_reader_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (wd_clear),
    .count  (wd_count),
    .expired(timeout)
  );

  // A byte landing on the expiry cycle wins over the timeout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= 1'b0;
    end else if ((state_q == S_WAIT) && !byte_in && timeout) begin
      err_q <= 1'b1;
    end
  end

  assign rsp_error = err_q;
`else
  assign timeout   = 1'b0;
  assign rsp_error = 1'b0;
`endif

endmodule

// File: tb/tb_flash_byte_reader.sv
// Randomised self-checking bench for flash_byte_reader with a behavioural loader model.
// Define FLASH_READER_TIMEOUT_EN to also exercise the watchdog path.
module tb_flash_byte_reader;

  localparam int unsigned AW       = 15;
  localparam int          AddrSpan = 1 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic [3:0]    req_page;
  logic [AW-1:0] req_byte_addr;
  logic [2:0]    req_len;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_data;
  logic          rsp_error;
  logic          loader_done;
  logic          flash_read_enable;
  logic [3:0]    page_index;
  logic [AW-1:0] flash_byte_addr;
  logic          flash_read_en_out = 1'b0;
  logic [7:0]    flash_byte_out = 8'h00;

  flash_byte_reader #(
    .FLASH_BYTE_ADDR_WIDTH(AW),
    .TIMEOUT_CYCLES       (255)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_page         (req_page),
    .req_byte_addr    (req_byte_addr),
    .req_len          (req_len),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .rsp_data         (rsp_data),
    .rsp_error        (rsp_error),
    .loader_done      (loader_done),
    .flash_read_enable(flash_read_enable),
    .page_index       (page_index),
    .flash_byte_addr  (flash_byte_addr),
    .flash_read_en_out(flash_read_en_out),
    .flash_byte_out   (flash_byte_out)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  bit          active = 0;
  logic [3:0]  exp_page = '0;
  logic [31:0] exp_word = '0;
  logic        exp_err = 1'b0;
  int          exp_addrs[$];
  int          seen_addrs[$];
  logic [7:0]  ret_bytes[$];
  logic [7:0]  preload[$];
  bit          outstanding = 0;
  int          countdown = 0;
  int          fixed_lat = 3;
  int          drop_after = -1;
  int          strobes = 0;
  int          first_strobe_cyc = 0;
  int          acc_cyc = 0;
  bit          stray_en = 0;
  bit          stray_once = 0;
  logic [7:0]  pend_byte = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] mem_byte(input int pg, input int a);
    return 8'((a * 37) ^ (a >> 7) ^ (pg * 91) ^ 60);
  endfunction

  // Per-cycle checker plus the loader model: one strobe in, one byte back after a latency.
  always @(negedge clk) begin
    bit was_out;
    bit pulsed;
    cyc++;
    was_out           = outstanding;
    pulsed            = 0;
    flash_read_en_out = 1'b0;
    if (reset) begin
      chk("reset_outputs", {flash_read_enable, rsp_valid, rsp_error, page_index, flash_byte_addr},
          32'd0);
      chk("reset_data", rsp_data, 32'd0);
      outstanding = 0;
    end else begin
      chk("req_ready", req_ready, !active && loader_done);
      if (active) chk("page_index", page_index, exp_page);
      if (rsp_valid) begin
        chk("rsp_valid_when_idle", active, 1);
        chk("rsp_data", rsp_data, exp_word);
        chk("rsp_error", rsp_error, exp_err);
        if (!exp_err) chk("strobes_left", exp_addrs.size(), 0);
        outstanding = 0;
      end
      if (outstanding && countdown > 0) begin
        countdown--;
        if (countdown == 0) begin
          flash_read_en_out = 1'b1;
          flash_byte_out    = pend_byte;
          outstanding       = 0;
          pulsed            = 1;
        end
      end
      if (!outstanding && !pulsed && (stray_once || (stray_en && $urandom_range(7) == 0))) begin
        flash_read_en_out = 1'b1;
        flash_byte_out    = 8'($urandom);
        stray_once        = 0;
      end
      if (flash_read_enable === 1'b1) begin
        chk("strobe_ok(active,outstanding,none_left)", {active, was_out, exp_addrs.size() == 0},
            32'b100);
        if (exp_addrs.size() > 0) chk("strobe_addr", flash_byte_addr, exp_addrs.pop_front());
        seen_addrs.push_back(int'(flash_byte_addr));
        if (strobes == 0) first_strobe_cyc = cyc;
        strobes++;
        outstanding = 1;
        if (drop_after >= 0 && strobes > drop_after) begin
          countdown = -1;
        end else begin
          countdown = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(6, 1));
          pend_byte = (ret_bytes.size() > 0) ? ret_bytes.pop_front() : 8'hee;
        end
      end
    end
  end

  // Call at posedge+#1; returns after the accepting edge with the model armed.
  task automatic start_req(input logic [3:0] pg, input int ad, input logic [2:0] ln,
                           input int drop, output int waited);
    int n;
    n             = (ln == 0) ? 1 : (ln > 4) ? 4 : int'(ln);
    req_valid     = 1'b1;
    req_page      = pg;
    req_byte_addr = AW'(ad);
    req_len       = ln;
    waited        = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (req_ready !== 1'b1 && waited < 200);
    if (req_ready !== 1'b1) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    exp_addrs.delete();
    ret_bytes.delete();
    seen_addrs.delete();
    exp_word = '0;
    exp_page = pg;
    strobes  = 0;
    for (int k = 0; k < n; k++) begin
      int         a;
      logic [7:0] b;
      a = (ad + k) % AddrSpan;
      b = (preload.size() > 0) ? preload.pop_front() : mem_byte(pg, a);
      exp_addrs.push_back(a);
      ret_bytes.push_back(b);
      if (drop < 0 || k < drop) exp_word |= 32'(b) << (8 * k);
    end
`ifdef FLASH_READER_TIMEOUT_EN
    exp_err = (drop >= 0 && drop < n);
`else
    exp_err = 1'b0;
`endif
    drop_after = drop;
    acc_cyc    = cyc;
    active     = 1;
  endtask

  task automatic apply_reset(input int cycles);
    @(posedge clk);
    #1;
    reset      = 1'b1;
    active     = 0;
    drop_after = -1;
    stray_once = 0;
    exp_addrs.delete();
    repeat (cycles) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic finish_req(input int bp, input bit stray_resp, output logic [31:0] data,
                            output logic err);
    int waited;
    waited = 0;
    while (rsp_valid !== 1'b1 && waited < 1000) begin
      @(negedge clk);
      waited++;
      req_valid     = 1'($urandom_range(1));
      req_page      = 4'($urandom);
      req_byte_addr = AW'($urandom);
      req_len       = 3'($urandom);
    end
    req_valid = 1'b0;
    if (rsp_valid !== 1'b1) begin
      chk("rsp_timeout", 0, 1);
      data = 'x;
      err  = 1'bx;
      apply_reset(2);
      return;
    end
    data = rsp_data;
    err  = rsp_error;
    for (int i = 0; i < bp; i++) begin
      if (stray_resp && i == 0) stray_once = 1;
      @(negedge clk);
      chk("bp_hold_valid", rsp_valid, 1);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready  = 1'b0;
    active     = 0;
    drop_after = -1;
    stray_once = 0;
    @(negedge clk);
    chk("rsp_released", rsp_valid, 0);
  endtask

  task automatic run_req(input logic [3:0] pg, input int ad, input logic [2:0] ln, input int bp,
                         input bit stray_resp, output logic [31:0] data, output logic err);
    int w;
    @(posedge clk);
    #1;
    start_req(pg, ad, ln, -1, w);
    finish_req(bp, stray_resp, data, err);
  endtask

  initial begin
    logic [31:0] d;
    logic        e;
    int          w;
    int          lit_word[4];
    int          lit_wrap[4];
    lit_word      = '{32'h0100, 32'h0101, 32'h0102, 32'h0103};
    lit_wrap      = '{32'h7ffe, 32'h7fff, 32'h0000, 32'h0001};
    reset         = 1'b1;
    req_valid     = 1'b0;
    req_page      = '0;
    req_byte_addr = '0;
    req_len       = '0;
    rsp_ready     = 1'b0;
    loader_done   = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Boot gating: request held while the loader is still copying.
    req_valid     = 1'b1;
    req_page      = 4'd1;
    req_byte_addr = AW'(5);
    req_len       = 3'd1;
    repeat (6) begin
      @(negedge clk);
      chk("boot_gate_ready", req_ready, 0);
    end
    @(posedge clk);
    #1;
    loader_done = 1'b1;
    start_req(4'd1, 5, 3'd1, -1, w);
    chk("boot_accept_wait", w, 1);
    finish_req(0, 0, d, e);
    chk("first_strobe_lat", first_strobe_cyc - acc_cyc, 2);

    // Word read with 3-cycle loader latency.
    fixed_lat = 3;
    preload   = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_req(4'd3, 'h0100, 3'd4, 0, 0, d, e);
    chk("word_data", d, 32'h44332211);
    chk("word_error", e, 0);
    chk("word_strobes", strobes, 4);
    for (int i = 0; i < 4; i++) chk("word_addr", seen_addrs[i], lit_word[i]);

    preload = '{8'hab, 8'hcd};
    run_req(4'd2, 'h0040, 3'd2, 0, 0, d, e);
    chk("short_data", d, 32'h0000cdab);

    preload = '{8'h5a};
    run_req(4'd2, 'h0050, 3'd0, 0, 0, d, e);
    chk("len0_data", d, 32'h0000005a);
    chk("len0_strobes", strobes, 1);

    preload = '{8'h01, 8'h02, 8'h03, 8'h04};
    run_req(4'd6, 'h0060, 3'd7, 0, 0, d, e);
    chk("len7_data", d, 32'h04030201);
    chk("len7_strobes", strobes, 4);

    run_req(4'd9, 'h7ffe, 3'd4, 0, 0, d, e);
    for (int i = 0; i < 4; i++) chk("wrap_addr", seen_addrs[i], lit_wrap[i]);

    // Backpressure with a stray loader pulse while the response waits.
    run_req(4'd4, 'h1234, 3'd3, 10, 1, d, e);

    // Reset after two bytes, with the third byte never returned.
    fixed_lat = 2;
    @(posedge clk);
    #1;
    start_req(4'd5, 'h2000, 3'd4, 2, w);
    w = 0;
    while (strobes < 3 && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("reset_test_strobes", strobes, 3);
    repeat (2) @(negedge clk);
    apply_reset(2);
    preload = '{8'h77};
    run_req(4'd5, 'h0010, 3'd1, 0, 0, d, e);
    chk("post_reset_data", d, 32'h00000077);
    chk("post_reset_addr", seen_addrs[0], 32'h0010);

`ifdef FLASH_READER_TIMEOUT_EN
    preload = '{8'h12, 8'h34};
    @(posedge clk);
    #1;
    start_req(4'd7, 'h0300, 3'd4, 2, w);
    finish_req(0, 0, d, e);
    chk("timeout_data", d, 32'h00003412);
    chk("timeout_error", e, 1);
    chk("timeout_strobes", strobes, 3);
`endif

    // Random traffic with stray pulses, random latency, and occasional loader_done drops.
    fixed_lat = 0;
    stray_en  = 1;
    for (int t = 0; t < 40; t++) begin
      logic [3:0] pg;
      int         ad;
      logic [2:0] ln;
      int         bp;
      pg = 4'($urandom);
      ad = ($urandom_range(3) == 0) ? AddrSpan - int'($urandom_range(4, 1))
                                    : int'($urandom_range(AddrSpan - 1));
      ln = 3'($urandom_range(7));
      bp = int'($urandom_range(3));
      if ($urandom_range(4) == 0) begin
        @(posedge clk);
        #1;
        start_req(pg, ad, ln, -1, w);
        loader_done = 1'b0;
        finish_req(bp, bp > 0, d, e);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        loader_done = 1'b1;
      end else begin
        run_req(pg, ad, ln, bp, bp > 0, d, e);
      end
    end
    stray_en = 0;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
